// File: rtl/control_estados_mascota_if.sv
// Handshake between the pet controller and the mode/level and display layers.
// The controller takes the slave view; the mode/level side takes the master view.
interface control_estados_mascota_if;
  logic       test_pulse;
  logic [1:0] Nivel_Animo;
  logic [1:0] Nivel_Energia;
  logic [1:0] Nivel_Descanso;
  logic [1:0] Nivel_Medicina;
  logic       fin_Energia;
  logic       fin_Medicina;
  logic       Activo_Comida;
  logic       Activo_Medicina;
  logic       Entrada_Animo;
  logic [2:0] Estado;
  logic       modo_test;
  logic       alerta;

  modport slave (
    input  test_pulse, Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina,
           fin_Energia, fin_Medicina,
    output Activo_Comida, Activo_Medicina, Entrada_Animo, Estado, modo_test, alerta
  );

  modport master (
    output test_pulse, Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina,
           fin_Energia, fin_Medicina,
    input  Activo_Comida, Activo_Medicina, Entrada_Animo, Estado, modo_test, alerta
  );
endinterface

// File: rtl/control_estados_mascota.sv
// Pet behaviour controller: Moore FSM over need levels, with a periodic mood
// stimulus while idle and a three-step test mode; all outputs registered.
module control_estados_mascota #(
  parameter int unsigned TICKS_ANIMO = 10,
  parameter int unsigned UMBRAL_BAJO = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  control_estados_mascota_if.slave      bus
);

  localparam int unsigned CW       = (TICKS_ANIMO > 1) ? $clog2(TICKS_ANIMO) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_ANIMO - 1);
  localparam logic [1:0]    UMBRAL   = 2'(UMBRAL_BAJO);

  // Encodings double as the displayed Estado code outside TEST
  typedef enum logic [2:0] {
    NEUTRO  = 3'd0,
    HAMBRE  = 3'd1,
    SUENO   = 3'd2,
    ENFERMO = 3'd3,
    MUERTO  = 3'd4,
    TEST    = 3'd5
  } estado_t;

  estado_t       state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;

  logic       muerto_c;
  logic       comida_n, medicina_n, animo_n, modo_n, alerta_n;
  logic [2:0] estado_n;

  assign muerto_c = (bus.Nivel_Animo == 2'd0) && (bus.Nivel_Energia == 2'd0) &&
                    (bus.Nivel_Descanso == 2'd0) && (bus.Nivel_Medicina == 2'd0);

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state               <= NEUTRO;
      cnt                 <= '0;
      idx                 <= '0;
      bus.Activo_Comida   <= 1'b0;
      bus.Activo_Medicina <= 1'b0;
      bus.Entrada_Animo   <= 1'b0;
      bus.Estado          <= 3'd0;
      bus.modo_test       <= 1'b0;
      bus.alerta          <= 1'b0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      idx                 <= idx_n;
      bus.Activo_Comida   <= comida_n;
      bus.Activo_Medicina <= medicina_n;
      bus.Entrada_Animo   <= animo_n;
      bus.Estado          <= estado_n;
      bus.modo_test       <= modo_n;
      bus.alerta          <= alerta_n;
    end
  end

  // Next state, counters and next output values
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = '0;
    animo_n = 1'b0;

    unique case (state)
      NEUTRO: begin
        if (bus.test_pulse) begin
          state_n = TEST;
          idx_n   = 2'd1;
        end else if (muerto_c) begin
          state_n = MUERTO;
        end else if (bus.Nivel_Medicina <= UMBRAL) begin
          state_n = ENFERMO;
        end else if (bus.Nivel_Energia <= UMBRAL) begin
          state_n = HAMBRE;
        end else if (bus.Nivel_Descanso <= UMBRAL) begin
          state_n = SUENO;
        end else if (cnt == CNT_LAST) begin
          animo_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      HAMBRE: begin
        if (bus.test_pulse) begin
          state_n = TEST;
          idx_n   = 2'd1;
        end else if (muerto_c) begin
          state_n = MUERTO;
        end else if (bus.fin_Energia) begin
          state_n = NEUTRO;
        end
      end

      ENFERMO: begin
        if (bus.test_pulse) begin
          state_n = TEST;
          idx_n   = 2'd1;
        end else if (muerto_c) begin
          state_n = MUERTO;
        end else if (bus.fin_Medicina) begin
          state_n = NEUTRO;
        end
      end

      SUENO: begin
        if (bus.test_pulse) begin
          state_n = TEST;
          idx_n   = 2'd1;
        end else if (muerto_c) begin
          state_n = MUERTO;
        end else if (bus.Nivel_Descanso > UMBRAL) begin
          state_n = NEUTRO;
        end
      end

      MUERTO: state_n = MUERTO;

      // Death check deliberately not applied here
      TEST: begin
        if (bus.test_pulse) begin
          if (idx == 2'd3) begin
            state_n = NEUTRO;
            idx_n   = 2'd0;
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end

      default: begin
        state_n = NEUTRO;
        idx_n   = 2'd0;
      end
    endcase

    comida_n   = (state_n == HAMBRE);
    medicina_n = (state_n == ENFERMO);
    modo_n     = (state_n == TEST);
    estado_n   = (state_n == TEST) ? {1'b0, idx_n} : 3'(state_n);
    alerta_n   = (estado_n == 3'd1) || (estado_n == 3'd2) || (estado_n == 3'd3);
  end

endmodule

// File: doc/control_estados_mascota.md
Name: control_estados_mascota

Overview:
Pet behaviour controller. It consumes the 2-bit need levels and end-of-action pulses produced by the mode/level block, and drives back that block's control inputs: Activo_Comida, Activo_Medicina and the periodic Entrada_Animo pulse. It also publishes a registered pet-state code for the display and a test-mode indicator. It sits between the mode/level block and the display/LED layer, and runs in the same clock domain.

Parameters:
TICKS_ANIMO, 10, clk cycles between Entrada_Animo pulses while in NEUTRO; must be >= 2.
UMBRAL_BAJO, 1, a level <= this value counts as "low"; range 0..2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk
test_pulse  input  1  debounced one-cycle test button pulse
Nivel_Animo  input  2  mood level, unsigned 0..3
Nivel_Energia  input  2  energy level, unsigned 0..3
Nivel_Descanso  input  2  rest level, unsigned 0..3
Nivel_Medicina  input  2  health level, unsigned 0..3
fin_Energia  input  1  one-cycle pulse: 5 s feeding window done
fin_Medicina  input  1  one-cycle pulse: 5 s medicine window done
Activo_Comida  output  1  enables the energy (feeding) mode
Activo_Medicina  output  1  enables the medicine mode
Entrada_Animo  output  1  one-cycle mood stimulus pulse
Estado  output  3  pet state code: 0 NEUTRO, 1 HAMBRE, 2 SUENO, 3 ENFERMO, 4 MUERTO
modo_test  output  1  1 while in TEST
alerta  output  1  1 when Estado is 1, 2 or 3

Behaviour:
- All outputs are registered (Moore). Each output reflects the state entered on the previous rising edge, so input-to-output latency is 1 cycle.
- Reset (reset == 0 at an edge): the state goes to NEUTRO, the animo counter goes to 0 and the test index goes to 0. Output values in reset: Estado = 0, Activo_Comida = 0, Activo_Medicina = 0, Entrada_Animo = 0, modo_test = 0, alerta = 0. Reset overrides every other input, including in MUERTO and TEST.
- Death check: if all four levels == 0 in any non-TEST state, the next state is MUERTO. MUERTO is sticky until reset. All Activo/pulse outputs are 0 in MUERTO, and test_pulse is ignored.
- NEUTRO: evaluated in this priority order:
  1. test_pulse -> TEST
  2. death check
  3. Nivel_Medicina <= UMBRAL_BAJO -> ENFERMO
  4. Nivel_Energia <= UMBRAL_BAJO -> HAMBRE
  5. Nivel_Descanso <= UMBRAL_BAJO -> SUENO
  6. otherwise stay in NEUTRO
- NEUTRO animo counter:
  - The counter increments every cycle spent in NEUTRO.
  - When it reaches TICKS_ANIMO-1, Entrada_Animo = 1 on the next cycle and the counter wraps to 0.
  - The counter clears to 0 on any exit from NEUTRO, so no pulse is emitted on the exit cycle.
- HAMBRE: Activo_Comida = 1. Exits to NEUTRO on the cycle after fin_Energia = 1. Level changes do not exit HAMBRE; only fin_Energia, test_pulse, the death check or reset do.
- ENFERMO: Activo_Medicina = 1. Exits to NEUTRO on the cycle after fin_Medicina = 1.
- SUENO: no Activo outputs. Exits to NEUTRO when Nivel_Descanso > UMBRAL_BAJO.
- Leaving HAMBRE, ENFERMO or SUENO always passes through NEUTRO for at least 1 cycle before any re-evaluation.
- Fin pulses received in any other state are ignored and not remembered.
- Priority in HAMBRE/ENFERMO/SUENO, highest first: test_pulse, then death check, then the state's own exit condition.
- TEST:
  - Entry sets the test index to 1 and modo_test = 1. Estado shows the test index.
  - Each further test_pulse advances the index 1 -> 2 -> 3. The pulse after index 3 exits to NEUTRO, with modo_test = 0 and the animo counter at 0.
  - Activo_Comida, Activo_Medicina and Entrada_Animo are forced to 0 in TEST. alerta follows Estado.
  - The death check is suppressed in TEST and applied normally after exit.
- Fin pulses arriving in the same cycle as test_pulse are dropped.
- Counter width is clog2(TICKS_ANIMO). No overflow is possible because the counter wraps at TICKS_ANIMO-1.

Test Plan:
- Reset sequence: hold reset = 0 for 3 cycles with all levels = 3, then release -> Estado = 0, all outputs 0; with TICKS_ANIMO = 10, Entrada_Animo pulses for 1 cycle every 10 cycles while levels stay at 3.
- Feeding: Energia drops 3 -> 1 -> next cycle Estado = 1, Activo_Comida = 1, alerta = 1; pulse fin_Energia -> next cycle Estado = 0, Activo_Comida = 0; Energia still 1 -> Estado = 1 again one cycle later.
- Priority: Medicina = 1 and Energia = 0 in the same cycle -> Estado = 3, Activo_Medicina = 1, Activo_Comida = 0; fin_Energia pulse is ignored; fin_Medicina pulse -> Estado = 0, then 1.
- Sleep: Descanso = 0 -> Estado = 2; Descanso = 2 -> Estado = 0 after 1 cycle; no Entrada_Animo pulse during SUENO or on its exit cycle.
- Test mode: from HAMBRE, apply 4 test_pulses spaced 5 cycles apart -> Estado 1, 2, 3 with modo_test = 1 and Activo_Comida = 0, then Estado = 0 with modo_test = 0; all levels = 0 during TEST -> no MUERTO until exit, then MUERTO 1 cycle after exit.
- Death and reset: all levels = 0 -> Estado = 4 held for 50 cycles despite test_pulse and fin pulses; reset = 0 for 1 cycle -> Estado = 0, counters cleared.
